// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t               state_q;
  state_t               state_d;
  logic [5:0]           cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     mcand_q;
  logic                 is_div_q;
  logic                 neg_res_q;
  logic                 neg_rem_q;
  logic                 dbz_q;

  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;
  logic                 start_dbz;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH+1:0]     div_sub;
  logic                 div_ge;
  logic [WIDTH-1:0]     quot;
  logic [WIDTH-1:0]     quot_out;
  logic [WIDTH-1:0]     rem_out;
  logic [2*WIDTH-1:0]   prod_out;

  // Operand magnitudes and result signs are fixed at start; the loop runs unsigned.
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign abs_a     = a_neg ? -a : a;
  assign abs_b     = b_neg ? -b : b;
  assign start_dbz = op[1] & (b == '0);

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

  // Restoring step: the low half of acc_q shifts dividend bits out and quotient bits in.
  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_sub   = {1'b0, div_shift} - {2'b0, mcand_q};
  assign div_ge    = rem_q[WIDTH] | ~div_sub[WIDTH+1];

  assign quot      = acc_q[WIDTH-1:0];
  assign quot_out  = neg_res_q ? -quot : quot;
  assign rem_out   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign prod_out  = neg_res_q ? -acc_q : acc_q;

  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = start_dbz ? FIN : CALC;
      CALC:    if (cnt_q == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      mcand_q     <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            is_div_q  <= op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dbz_q     <= start_dbz;
            if (op[1]) begin
              mcand_q <= abs_b;
              acc_q   <= {{WIDTH{1'b0}}, abs_a};
            end else begin
              mcand_q <= abs_a;
              acc_q   <= {{WIDTH{1'b0}}, abs_b};
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 6'd1;
          if (is_div_q) begin
            rem_q             <= div_ge ? div_sub[WIDTH:0] : div_shift;
            acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          end
        end
        FIN: begin
          done        <= 1'b1;
          div_by_zero <= dbz_q;
          if (!dbz_q) begin
            if (is_div_q) begin
              hi <= rem_out;
              lo <= quot_out;
            end else begin
              hi <= prod_out[2*WIDTH-1:WIDTH];
              lo <= prod_out[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized scoreboard bench for muldiv_unit
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'd0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    logic        d;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          passed = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        last_dbz = 1'b0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    longint          sx;
    longint          sy;
    longint          q;
    longint          r;
    exp_t            e;
    e.d = 1'b0;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        m_hi = sp[63:32]; m_lo = sp[31:0];
      end
      2'd1: begin
        up = {32'h0, x} * {32'h0, y};
        m_hi = up[63:32]; m_lo = up[31:0];
      end
      2'd2: begin
        if (y == 0) e.d = 1'b1;
        else begin
          sx = longint'($signed(x)); sy = longint'($signed(y));
          q = sx / sy; r = sx % sy;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      default: begin
        if (y == 0) e.d = 1'b1;
        else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
    endcase
    e.h = m_hi; e.l = m_lo;
    last_dbz = e.d;
    sb_q.push_back(e);
  endtask

  // Called at #1 after a posedge with the unit idle; returns at #1 after E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (hi_we) m_hi = wdata;
    if (lo_we) m_lo = wdata;
    op_i = o; a_i = x; b_i = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom_range(0, 3));
    model(o, x, y);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 200);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat;
    start_op(o, x, y);
    check("busy_after_start", busy, 1);
    wait_done(lat);
    check("latency", lat, last_dbz ? 1 : 33);
    check("busy_at_done", busy, 0);
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d);
    hi_we = hw; lo_we = lw; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (hw) m_hi = d;
    if (lw) m_lo = d;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] specials [5];
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFFFFFF;
    specials[3] = 32'h80000000; specials[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (prev_done) check("done_width", done, 0);
    if (done) begin
      if (sb_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("res_hi", hi, e.h);
        check("res_lo", lo, e.l);
        check("res_dbz", div_by_zero, e.d);
      end
    end else if (div_by_zero) begin
      check("dbz_without_done", div_by_zero, 0);
    end
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    total++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    int lat;
    logic [31:0] h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'd0, 32'hFFFFFFFD, 32'd5);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2);
    run_op(2'd3, 32'd7, 32'd2);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    mt_write(1'b1, 1'b0, 32'h11111111);
    mt_write(1'b0, 1'b1, 32'h22222222);
    run_op(2'd3, 32'd99, 32'd0);
    run_op(2'd2, 32'd5, 32'd0);

    // Write and start in the same idle cycle: write lands, result overwrites later.
    hi_we = 1'b1; wdata = 32'h5A5A5A5A;
    start_op(2'd1, 32'd6, 32'd7);
    check("same_cycle_write", hi, 32'h5A5A5A5A);
    wait_done(lat);
    check("latency_sc", lat, 33);

    // Start and MTHI while busy are ignored.
    h0 = m_hi;
    start_op(2'd1, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; op_i = 2'd0; a_i = 32'd100; b_i = 32'd7; hi_we = 1'b1; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("busy_hold_hi", hi, h0);
    wait_done(lat);
    check("latency_busy_start", lat, 23);
    repeat (40) @(posedge clk);
    #1;
    check("idle_after_ignored", busy, 0);

    // Reset mid-operation aborts with no done pulse.
    start_op(2'd1, 32'h1234, 32'h5678);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dbz", div_by_zero, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_idle", busy, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 5) == 0) begin
        hi_we = 1'($urandom_range(0, 1)); lo_we = 1'($urandom_range(0, 1)); wdata = $urandom;
      end
      run_op(2'($urandom_range(0, 3)), pick(), ($urandom_range(0, 7) == 0) ? 32'h0 : pick());
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
